pc_unit: RTL and testbench

Registered program-counter unit for the MIPS-32 fetch stage, replacing the combinational next-PC path. It holds the PC and selects the next PC from sequential, branch, jump, jump-register or predicted-return sources, and supports stall. An optional return-address stack (RAS) predicts `jr $ra` targets from prior `jal` calls.

---
 rtl/pc_pkg.sv | 15 +
 rtl/ras_stack.sv | 59 +++++
 rtl/pc_unit.sv | 101 ++++++++++
 tb/tb_pc_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and next-PC select encoding for pc_unit
package pc_pkg;

  localparam int PC_INC       = 4;
  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_BR,
    NPC_JMP,
    NPC_JR,
    NPC_RET
  } npc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with saturating count and sticky overflow
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            valid_o,
  output logic            overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // ptr_q points at the next free slot; the top entry lives one below it
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic [PW-1:0]   top_idx;
  logic            pop_eff;

  assign top_idx    = ptr_q - PW'(1);
  assign valid_o    = (cnt_q != '0);
  assign pop_eff    = pop_i & valid_o;
  assign top_o      = mem_q[top_idx];
  assign overflow_o = ovf_q;

  // Storage is intentionally not reset; a push-with-pop rewrites the top in place
  always_ff @(posedge clk) begin
    if (push_i) begin
      if (pop_eff) mem_q[top_idx] <= data_i;
      else         mem_q[ptr_q]   <= data_i;
    end
  end

  // Pointer, occupancy and sticky overflow; a full push wraps over the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (push_i && !pop_eff) begin
      ptr_q <= ptr_q + PW'(1);
      if (cnt_q == CW'(DEPTH)) ovf_q <= 1'b1;
      else                     cnt_q <= cnt_q + CW'(1);
    end else if (pop_eff && !push_i) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - registered MIPS-32 fetch PC with branch/jump/jr/return select; RAS under PC_RAS_EN
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [15:0]     br_offset,
  input  logic            jump,
  input  logic [25:0]     jump_target,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_addr,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] ret_pred,
  output logic            ret_valid,
  output logic            ras_overflow
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] br_tgt, jmp_tgt, jr_tgt;
  logic [XLEN-1:0] ras_top;
  logic            ras_valid, ras_ovf;
  logic            ret_take;
  npc_sel_e        sel;

  // jr targets are word aligned, so the low address bits never matter
  logic unused_jr_lo;
  assign unused_jr_lo = ^jr_addr[1:0];

  assign pc_plus4 = pc_q + XLEN'(PC_INC);
  assign br_tgt   = pc_plus4 + {{(XLEN-18){br_offset[15]}}, br_offset, 2'b00};
  assign jmp_tgt  = {pc_plus4[XLEN-1:28], jump_target, 2'b00};
  assign jr_tgt   = {jr_addr[XLEN-1:2], 2'b00};

`ifdef PC_RAS_EN
  // The stack sees the raw ret; it drops the pop itself when empty, and pops even if jr wins
  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (reset),
    .push_i     (call & ~stall),
    .pop_i      (ret & ~stall),
    .data_i     (pc_plus4),
    .top_o      (ras_top),
    .valid_o    (ras_valid),
    .overflow_o (ras_ovf)
  );
  assign ret_take = ret & ras_valid;
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras_ctl;
  assign unused_ras_ctl = call ^ ret;
  assign ras_top   = '0;
  assign ras_valid = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ret_take  = 1'b0;
`endif

  assign ret_pred     = ras_top;
  assign ret_valid    = ras_valid;
  assign ras_overflow = ras_ovf;
  assign pc           = pc_q;

  // Redirect priority: jr, predicted return, jump, branch, then fall-through
  always_comb begin
    sel = NPC_SEQ;
    if (jr)                sel = NPC_JR;
    else if (ret_take)     sel = NPC_RET;
    else if (jump)         sel = NPC_JMP;
    else if (branch_taken) sel = NPC_BR;
  end

  // Target mux for the selected source
  always_comb begin
    pc_d = pc_plus4;
    case (sel)
      NPC_JR:  pc_d = jr_tgt;
      NPC_RET: pc_d = ras_top;
      NPC_JMP: pc_d = jmp_tgt;
      NPC_BR:  pc_d = br_tgt;
      default: pc_d = pc_plus4;
    endcase
  end

  // PC register; stall holds the current fetch address
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pc_q <= RESET_VECTOR;
    else if (!stall) pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - randomized self-checking bench for pc_unit against a behavioural model
module tb_pc_unit;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0040_0000;
  localparam int          DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0, call = 1'b0, ret = 1'b0;
  logic [15:0] br_offset = '0;
  logic [25:0] jump_target = '0;
  logic [31:0] jr_addr = '0;
  logic [31:0] pc, pc_plus4, ret_pred;
  logic        ret_valid, ras_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  pc_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .br_offset    (br_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .call         (call),
    .ret          (ret),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .ret_pred     (ret_pred),
    .ret_valid    (ret_valid),
    .ras_overflow (ras_overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: the RAS is a plain list of return addresses, newest last
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_ovf;

  always @(posedge clk or posedge reset) begin
    logic [31:0] p4, nxt, off;
    bit          has;
    if (reset) begin
      m_pc  = RV;
      m_q   = {};
      m_ovf = 1'b0;
    end else if (!stall) begin
      p4  = m_pc + 32'd4;
      has = RAS_EN && (m_q.size() > 0);
      off = 32'($signed(br_offset)) * 32'd4;
      if (jr)                nxt = jr_addr & 32'hFFFF_FFFC;
      else if (ret && has)   nxt = m_q[m_q.size()-1];
      else if (jump)         nxt = (p4 & 32'hF000_0000) | (32'(jump_target) * 32'd4);
      else if (branch_taken) nxt = p4 + off;
      else                   nxt = p4;
      if (RAS_EN) begin
        if (call && ret && has) begin
          m_q[m_q.size()-1] = p4;
        end else begin
          if (ret && has) void'(m_q.pop_back());
          if (call) begin
            m_q.push_back(p4);
            if (m_q.size() > DEPTH) begin
              void'(m_q.pop_front());
              m_ovf = 1'b1;
            end
          end
        end
      end
      m_pc = nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are settled 3 time units after every rising edge
  always @(posedge clk) begin
    #3;
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("ret_valid", 32'(ret_valid), 32'(m_q.size() > 0));
    chk("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    if (m_q.size() > 0) chk("ret_pred", ret_pred, m_q[m_q.size()-1]);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_ctl();
    stall = 0; branch_taken = 0; jump = 0; jr = 0; call = 0; ret = 0;
    br_offset = '0; jump_target = '0; jr_addr = '0;
  endtask

  task automatic jump_to(input logic [31:0] a);
    jr = 1; jr_addr = a;
    tick();
    clear_ctl();
  endtask

  initial begin
    // Reset and sequential fetch
    clear_ctl();
    reset = 1;
    tick(); tick();
    chk("reset pc", pc, RV);
    chk("reset ret_valid", 32'(ret_valid), 32'd0);
    chk("reset ras_overflow", 32'(ras_overflow), 32'd0);
    reset = 0;
    chk("released pc", pc, 32'h0040_0000);
    tick();
    chk("seq 1", pc, 32'h0040_0004);
    tick();
    chk("seq 2", pc, 32'h0040_0008);

    // Negative branch offset and 32-bit wrap
    jump_to(32'h0040_0010);
    branch_taken = 1; br_offset = 16'hFFFC;
    tick();
    clear_ctl();
    chk("branch negative", pc, 32'h0040_0004);
    jump_to(32'hFFFF_FFFC);
    branch_taken = 1; br_offset = 16'h0000;
    tick();
    clear_ctl();
    chk("branch wrap", pc, 32'h0000_0000);

    // Priority: jr over jump and branch, then stall holds everything
    jr = 1; jr_addr = 32'h1000_0003; jump = 1; jump_target = 26'h3; branch_taken = 1; br_offset = 16'h5;
    tick();
    chk("jr priority", pc, 32'h1000_0000);
    stall = 1;
    tick();
    chk("stall hold", pc, 32'h1000_0000);
    clear_ctl();

    // Call then return
    jump_to(32'h0040_0020);
    jump = 1; call = 1; jump_target = 26'h010_0000;
    tick();
    clear_ctl();
    chk("jal target", pc, 32'h0040_0000);
    if (RAS_EN) begin
      chk("jal ret_pred", ret_pred, 32'h0040_0024);
      chk("jal ret_valid", 32'(ret_valid), 32'd1);
    end
    ret = 1;
    tick();
    clear_ctl();
    chk("ret target", pc, RAS_EN ? 32'h0040_0024 : 32'h0040_0004);
    chk("ret drains", 32'(ret_valid), 32'd0);

    // Five pushes into four entries, then five returns
    reset = 1; tick(); reset = 0;
    call = 1;
    for (int i = 0; i < 5; i++) tick();
    clear_ctl();
    chk("overflow flag", 32'(ras_overflow), 32'(RAS_EN));
    ret = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (RAS_EN) chk("ras pop", pc, (i < 4) ? RV + 32'(20 - 4*i) : RV + 32'd12);
      else        chk("ras pop", pc, RV + 32'(20 + 4*(i+1)));
    end
    clear_ctl();
    chk("overflow sticky", 32'(ras_overflow), 32'(RAS_EN));

    // Asynchronous reset with a redirect pending
    jr = 1; jr_addr = 32'h1234_5678;
    #2 reset = 1;
    #1 chk("async reset pc", pc, RV);
    tick();
    reset = 0;
    clear_ctl();
    tick();
    chk("post reset pc", pc, RV + 32'd4);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      stall        = ($urandom_range(7) == 0);
      jr           = ($urandom_range(9) == 0);
      ret          = ($urandom_range(3) == 0);
      call         = ($urandom_range(3) == 0);
      jump         = ($urandom_range(9) == 0);
      branch_taken = ($urandom_range(3) == 0);
      br_offset    = 16'($urandom);
      jump_target  = 26'($urandom);
      jr_addr      = $urandom;
      reset        = ($urandom_range(499) == 0);
      tick();
    end
    reset = 0;
    clear_ctl();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
